uart_loader: RTL
================

Name: uart_loader

Overview:
- Bus initiator that drives the UART block's register port (cs / data_reg / wren / di / do) to bootload a program image into word memory.
- On start it polls RX status, receives a 4-byte little-endian length followed by that many payload bytes, and packs the bytes into 32-bit little-endian words written to memory.
- After the payload it returns an 8-bit additive checksum over the TX path.
- Sits between the UART block and the instruction RAM write port; it is muxed against the CPU bus and owns the UART only while busy.

Parameters:
- ADDR_W, 10, memory word-address width.
- BASE_ADDR, 0, word address of the first stored word.
- MAX_BYTES, 4096, largest accepted payload length; must be <= 4*2^ADDR_W.

Ports:
- clk  in  1  system clock, all logic on rising edge
- n_reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load when idle, ignored while busy
- busy  out  1  high from accepted start until DONE or ERR
- done  out  1  sticky high after a successful load; cleared by next start
- err  out  1  sticky high after length > MAX_BYTES; cleared by next start
- ub_cs  out  1  UART block select
- ub_data_reg  out  1  1 = data register, 0 = status register
- ub_wren  out  1  write strobe
- ub_di  out  8  TX byte
- ub_do  in  8  UART read data, valid the cycle after ub_cs; bit0 = rx_has_data, bit1 = tx_buf_empty
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  packed word
- mem_we  out  1  one-cycle write pulse

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; length, byte count, checksum and word register cleared.
  - Reset mid-load aborts immediately; no further UART or memory strobes are issued.
- UART access rule:
  - ub_cs is high for exactly one cycle per access.
  - ub_do is sampled in the following cycle only.
  - Never two accesses in consecutive cycles.
  - ub_wren and ub_data_reg are 0 whenever ub_cs is 0.
- States and transitions:
  - IDLE: on start, clear done, err, counters and checksum; set busy; go to RX_POLL.
  - RX_POLL: cs=1, data_reg=0, wren=0 -> RX_CHK.
  - RX_CHK: if ub_do[0] go to RX_READ, else go to RX_POLL (2-cycle poll period).
  - RX_READ: cs=1, data_reg=1 -> RX_CAPT.
  - RX_CAPT: take the byte from ub_do.
    - Header phase (4 bytes): shift into length[31:0], LSB first. After the 4th byte:
      - length > MAX_BYTES: go to ERR.
      - length == 0: go to TX_POLL.
      - otherwise: go to RX_POLL.
    - Payload phase:
      - Place the byte in lane (idx mod 4) of the word register; checksum += byte (mod 256); idx += 1.
      - If lane == 3 or idx == length, go to STORE; else go to RX_POLL.
  - STORE:
    - mem_we=1, mem_addr = BASE_ADDR + (idx-1)/4, truncated to ADDR_W.
    - mem_wdata = word register; unfilled upper lanes of a final partial word are 0.
    - Clear the word register.
    - If idx == length, go to TX_POLL; else go to RX_POLL.
  - TX_POLL: cs=1, data_reg=0 -> TX_CHK.
  - TX_CHK: if ub_do[1] go to TX_SEND, else go to TX_POLL.
  - TX_SEND: cs=1, wren=1, di=checksum -> DONE.
  - DONE: busy=0, done=1 -> IDLE.
  - ERR: busy=0, err=1, nothing transmitted -> IDLE.
- Latency:
  - Minimum 4 cycles per received byte (poll, check, read, capture), plus 1 cycle per stored word.
  - done rises 2 cycles after the TX_CHK that saw tx_buf_empty.
- Boundary conditions:
  - Memory address wraps modulo 2^ADDR_W when BASE_ADDR is non-zero.
  - length == MAX_BYTES is accepted.
  - A start pulse while busy is ignored.
  - A start in the same cycle DONE/ERR returns to IDLE is ignored; a start is accepted only while in IDLE.
  - Bytes arriving after the payload stay in the UART and are not consumed.

Test Plan:
- Send length 04 00 00 00, payload 11 22 33 44 -> one mem_we, addr 0, wdata 0x44332211; TX byte 0xAA; done=1, err=0.
- Length 6, payload 01..06, BASE_ADDR=0x10 -> writes 0x04030201 @0x10 and 0x00000605 @0x11; checksum 0x15.
- Length 0 -> no mem_we; TX 0x00; done=1.
- Length 0x1001 with MAX_BYTES=4096 -> err=1, no mem_we, no ub_wren; length 0x1000 is accepted.
- Hold status bit1=0 for 20 cycles after the payload -> only status polls, ub_wren stays 0 until bit1=1; ub_cs is never high in two consecutive cycles.
- Assert n_reset low mid-payload, then pulse start again -> all outputs 0 during reset; the new load fully reinitialises and completes correctly.

Source files
------------

// File: rtl/uart_loader_if.sv
// UART block register port, seen from the loader (master) and the UART block (slave).
//
// Access protocol:
// - ub_cs is a one-cycle select for a single register access.
// - ub_data_reg selects the data register (1) or the status register (0).
// - ub_wren marks the access as a write of ub_di.
// - ub_do carries the read result during the cycle after the select.
// - Accesses are never issued back to back.
// - ub_data_reg and ub_wren are 0 whenever ub_cs is 0.
interface uart_loader_if;
  logic       ub_cs;
  logic       ub_data_reg;
  logic       ub_wren;
  logic [7:0] ub_di;
  logic [7:0] ub_do;

  modport master (
    output ub_cs,
    output ub_data_reg,
    output ub_wren,
    output ub_di,
    input  ub_do
  );

  modport slave (
    input  ub_cs,
    input  ub_data_reg,
    input  ub_wren,
    input  ub_di,
    output ub_do
  );
endinterface

// File: rtl/uart_loader.sv
// Bootloader: reads a 4-byte LE length and a payload from the UART, packs the
// payload into 32-bit LE words written to memory, then returns an additive
// 8-bit checksum over the TX path.
module uart_loader #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_BYTES = 4096
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  uart_loader_if.master     ub,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic [3:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       MAX_LEN = 32'(MAX_BYTES);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RX_POLL = 4'd1,
    S_RX_CHK  = 4'd2,
    S_RX_READ = 4'd3,
    S_RX_CAPT = 4'd4,
    S_STORE   = 4'd5,
    S_TX_POLL = 4'd6,
    S_TX_CHK  = 4'd7,
    S_TX_SEND = 4'd8,
    S_DONE    = 4'd9,
    S_ERR     = 4'd10
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       len_q, len_d;
  logic [2:0]        hdr_cnt_q, hdr_cnt_d;   // header bytes taken, 4 = payload phase
  logic [31:0]       idx_q, idx_d;           // payload bytes taken
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;       // address of the word being assembled
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [7:0]        rx_byte;
  logic [31:0]       len_full;
  logic [31:0]       idx_inc;

  // State and datapath registers; reset drops the load immediately.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      hdr_cnt_q <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      csum_q    <= '0;
      waddr_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      hdr_cnt_q <= hdr_cnt_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      csum_q    <= csum_d;
      waddr_q   <= waddr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next state plus header/payload capture, word packing and checksum.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    hdr_cnt_d = hdr_cnt_q;
    idx_d     = idx_q;
    word_d    = word_q;
    csum_d    = csum_q;
    waddr_d   = waddr_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    rx_byte   = ub.ub_do;
    len_full  = {rx_byte, len_q[31:8]};
    idx_inc   = idx_q + 32'd1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RX_POLL;
          len_d     = '0;
          hdr_cnt_d = '0;
          idx_d     = '0;
          word_d    = '0;
          csum_d    = '0;
          waddr_d   = BASE_A;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
        end
      end
      S_RX_POLL: state_d = S_RX_CHK;
      S_RX_CHK:  state_d = ub.ub_do[0] ? S_RX_READ : S_RX_POLL;
      S_RX_READ: state_d = S_RX_CAPT;
      S_RX_CAPT: begin
        if (hdr_cnt_q != 3'd4) begin
          // Length arrives LSB first, so shift new bytes in from the top.
          len_d     = len_full;
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          state_d   = S_RX_POLL;
          if (hdr_cnt_q == 3'd3) begin
            if (len_full > MAX_LEN) begin
              state_d = S_ERR;
              busy_d  = 1'b0;
              err_d   = 1'b1;
            end else if (len_full == 32'd0) begin
              state_d = S_TX_POLL;
            end
          end
        end else begin
          word_d  = word_q | ({24'd0, rx_byte} << {idx_q[1:0], 3'b000});
          csum_d  = csum_q + rx_byte;
          idx_d   = idx_inc;
          state_d = ((idx_q[1:0] == 2'd3) || (idx_inc == len_q)) ? S_STORE : S_RX_POLL;
        end
      end
      S_STORE: begin
        word_d  = '0;
        waddr_d = waddr_q + 1'b1;
        state_d = (idx_q == len_q) ? S_TX_POLL : S_RX_POLL;
      end
      S_TX_POLL: state_d = S_TX_CHK;
      S_TX_CHK:  state_d = ub.ub_do[1] ? S_TX_SEND : S_TX_POLL;
      S_TX_SEND: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // UART and memory strobes decoded from the current state only.
  always_comb begin
    ub.ub_cs       = 1'b0;
    ub.ub_data_reg = 1'b0;
    ub.ub_wren     = 1'b0;
    ub.ub_di       = '0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    case (state_q)
      S_RX_POLL, S_TX_POLL: ub.ub_cs = 1'b1;
      S_RX_READ: begin
        ub.ub_cs       = 1'b1;
        ub.ub_data_reg = 1'b1;
      end
      S_TX_SEND: begin
        ub.ub_cs       = 1'b1;
        ub.ub_data_reg = 1'b1;
        ub.ub_wren     = 1'b1;
        ub.ub_di       = csum_q;
      end
      S_STORE: begin
        mem_we    = 1'b1;
        mem_addr  = waddr_q;
        mem_wdata = word_q;
      end
      default: ;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
